// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner
//   Consumer of the falling-stick map framebuffer. Latches a new 64-bit map
//   into a shadow buffer only at frame boundaries (tear-free), scans the
//   shadow row by row onto an 8x8 LED matrix, overlays the player pixel on
//   the bottom row and pulses a collision flag when a newly latched map
//   covers the player column.
//
// Ports
//   system_clk    clock
//   rst           synchronous reset, active low
//   framebuffer   map, row r = framebuffer[8r+7:8r], row 0 top, row 7 bottom
//   frame_update  generator strobe, rising edge = new map available
//   player_col    player column on the bottom row
//   player_en     enables player overlay and collision check
//   row_sel       active-low one-hot row drive
//   col_data      active-high column data
//   frame_start   one-cycle pulse in the first cycle of each frame
//   hit           one-cycle collision pulse in the first cycle after a copy
module led_matrix_scanner #(
  parameter int ROW_TICKS   = 16,
  parameter int BLANK_TICKS = 2
) (
  input  logic        system_clk,
  input  logic        rst,
  input  logic [63:0] framebuffer,
  input  logic        frame_update,
  input  logic [2:0]  player_col,
  input  logic        player_en,
  output logic [7:0]  row_sel,
  output logic [7:0]  col_data,
  output logic        frame_start,
  output logic        hit
);

  localparam int TICK_W = (ROW_TICKS > 1) ? $clog2(ROW_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(ROW_TICKS - 1);
  localparam logic [TICK_W-1:0] TICK_BLANK = TICK_W'(BLANK_TICKS);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  logic [TICK_W-1:0] tick_cnt, tick_nxt;
  logic [2:0]        row, row_nxt;
  state_t            state, state_nxt;
  logic [7:0][7:0]   shadow, shadow_nxt;
  logic              pending, upd_d;
  logic              rise, tick_wrap, frame_end, copy;
  logic [7:0]        drive_row;

  always_comb begin
    tick_wrap  = (tick_cnt == TICK_LAST);
    tick_nxt   = tick_wrap ? '0 : tick_cnt + TICK_W'(1);
    row_nxt    = tick_wrap ? row + 3'd1 : row;
    frame_end  = tick_wrap && (row == 3'd7);
    rise       = frame_update & ~upd_d;
    // A rise landing on the frame-end edge is taken by this copy directly.
    copy       = frame_end & (pending | rise);
    shadow_nxt = copy ? framebuffer : shadow;

    state_nxt = state;
    case (state)
      ST_BLANK: if (tick_nxt >= TICK_BLANK) state_nxt = ST_DRIVE;
      ST_DRIVE: if (tick_wrap && (BLANK_TICKS > 0)) state_nxt = ST_BLANK;
      default:  state_nxt = ST_BLANK;
    endcase

    // Outputs are built from next-state values so they line up with the
    // row/tick the counters hold during the cycle they are visible.
    drive_row = shadow_nxt[row_nxt];
    if (player_en && (row_nxt == 3'd7))
      drive_row = drive_row | (8'd1 << player_col);
  end

  always_ff @(posedge system_clk) begin
    if (!rst) begin
      tick_cnt    <= '0;
      row         <= 3'd0;
      state       <= ST_BLANK;
      shadow      <= '0;
      pending     <= 1'b0;
      upd_d       <= 1'b0;
      row_sel     <= 8'hFF;
      col_data    <= 8'h00;
      frame_start <= 1'b0;
      hit         <= 1'b0;
    end else begin
      tick_cnt    <= tick_nxt;
      row         <= row_nxt;
      state       <= state_nxt;
      upd_d       <= frame_update;
      shadow      <= shadow_nxt;
      // Rises within one frame collapse into a single pending flag.
      pending     <= copy ? 1'b0 : (pending | rise);
      frame_start <= frame_end;
      // Evaluated only on the copy edge, so it fires once per new map.
      hit         <= copy & player_en & shadow_nxt[7][player_col];
      if (state_nxt == ST_DRIVE) begin
        row_sel  <= ~(8'd1 << row_nxt);
        col_data <= drive_row;
      end else begin
        row_sel  <= 8'hFF;
        col_data <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Randomized + directed bench for led_matrix_scanner against a frame-position
// reference model (position within frame, shadow map, pending flag).
module tb_led_matrix_scanner;
  localparam int RT    = 16;
  localparam int BT    = 2;
  localparam int FRAME = 8 * RT;

  logic        system_clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] framebuffer = '0;
  logic        frame_update = 1'b0;
  logic [2:0]  player_col = 3'd0;
  logic        player_en = 1'b0;
  logic [7:0]  row_sel, col_data;
  logic        frame_start, hit;

  led_matrix_scanner #(.ROW_TICKS(RT), .BLANK_TICKS(BT)) dut (
    .system_clk(system_clk), .rst(rst), .framebuffer(framebuffer),
    .frame_update(frame_update), .player_col(player_col), .player_en(player_en),
    .row_sel(row_sel), .col_data(col_data), .frame_start(frame_start), .hit(hit)
  );

  always #5 system_clk = ~system_clk;

  // reference model
  int          m_cyc = 0;
  logic [63:0] m_shadow = '0;
  bit          m_pend = 0, m_upd = 0;
  logic [7:0]  e_rs = 8'hFF, e_cd = 8'h00;
  logic        e_fs = 0, e_hit = 0;

  int n_chk = 0, n_fail = 0, obs_hits = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (frame pos %0d, t=%0t)", tag, obs, exp, m_cyc, $time);
    end
  endtask

  task automatic model_edge();
    bit rise, cpy;
    int r, t;
    if (!rst) begin
      m_cyc = 0; m_shadow = '0; m_pend = 0; m_upd = 0;
      e_rs = 8'hFF; e_cd = 8'h00; e_fs = 0; e_hit = 0;
      return;
    end
    rise  = frame_update && !m_upd;
    m_upd = frame_update;
    cpy   = (m_cyc == FRAME - 1) && (m_pend || rise);
    if (cpy) begin
      m_shadow = framebuffer;
      m_pend   = 0;
    end else if (rise) m_pend = 1;
    m_cyc = (m_cyc + 1) % FRAME;
    r = m_cyc / RT;
    t = m_cyc % RT;
    e_fs  = (m_cyc == 0);
    e_hit = cpy && player_en && m_shadow[56 + player_col];
    if (t < BT) begin
      e_rs = 8'hFF; e_cd = 8'h00;
    end else begin
      e_rs = ~(8'd1 << r);
      e_cd = 8'((m_shadow >> (8 * r)) & 64'hFF);
      if (r == 7 && player_en) e_cd = e_cd | (8'd1 << player_col);
    end
  endtask

  task automatic step();
    @(posedge system_clk);
    model_edge();
    #1;
    if (hit === 1'b1) obs_hits++;
    chk("row_sel", 64'(row_sel), 64'(e_rs));
    chk("col_data", 64'(col_data), 64'(e_cd));
    chk("frame_start", 64'(frame_start), 64'(e_fs));
    chk("hit", 64'(hit), 64'(e_hit));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(input int c);
    int k = 0;
    while (m_cyc != c && k < 2 * FRAME) begin
      step();
      k++;
    end
    if (m_cyc != c) chk("run_to_timeout", 64'(m_cyc), 64'(c));
  endtask

  task automatic pulse_update();
    frame_update = 1'b1; step();
    frame_update = 1'b0; step();
  endtask

  task automatic do_reset();
    rst = 1'b0; run(2); rst = 1'b1;
  endtask

  int h0;
  logic [63:0] val_b, val_c;

  initial begin
    // reset state
    rst = 1'b0;
    run(2);
    chk("reset_row_sel", 64'(row_sel), 64'hFF);
    chk("reset_col_data", 64'(col_data), 64'h00);
    chk("reset_frame_start", 64'(frame_start), 64'h0);
    chk("reset_hit", 64'(hit), 64'h0);
    rst = 1'b1;

    // idle frame, blank map
    run(FRAME + 2);

    // single row map, rise mid-frame
    run_to(39);
    framebuffer = 64'h0000_0000_0000_00FE;
    pulse_update();
    run_to(BT);
    chk("row0_map", 64'(col_data), 64'hFE);
    run(FRAME);

    // tearing: A then B before the copy edge, then C without a rise
    framebuffer = 64'hAAAA_AAAA_AAAA_AAAA;
    run_to(10);
    pulse_update();
    run_to(70);
    val_b = 64'h1234_5678_9ABC_DEF0;
    framebuffer = val_b;
    run_to(3 * RT + 5);
    chk("tear_row3", 64'(col_data), 64'(val_b[31:24]));
    val_c = 64'h0F0F_0F0F_0F0F_0F0F;
    framebuffer = val_c;
    run(FRAME);
    run_to(3 * RT + 5);
    chk("hold_row3", 64'(col_data), 64'(val_b[31:24]));

    // collision: top byte FB, player in column 3 (hit), 2 (no hit), disabled
    framebuffer = 64'hFB00_0000_0000_0000;
    player_en = 1'b1; player_col = 3'd3;
    h0 = obs_hits;
    pulse_update();
    run_to(1);
    run(FRAME);
    chk("hit_col3_count", 64'(obs_hits - h0), 64'd1);
    player_col = 3'd2;
    h0 = obs_hits;
    pulse_update();
    run_to(7 * RT + 4);
    chk("row7_col2_overlay", 64'(col_data), 64'hFF);
    run(FRAME);
    chk("hit_col2_count", 64'(obs_hits - h0), 64'd0);
    player_en = 1'b0; player_col = 3'd3;
    h0 = obs_hits;
    pulse_update();
    run(FRAME);
    run_to(7 * RT + 4);
    chk("row7_noplayer", 64'(col_data), 64'hFB);
    chk("hit_disabled_count", 64'(obs_hits - h0), 64'd0);

    // two rises in one frame -> one copy, one hit
    framebuffer = 64'hFF00_0000_0000_0000;
    player_en = 1'b1; player_col = 3'd5;
    run_to(5);
    h0 = obs_hits;
    pulse_update();
    run(20);
    pulse_update();
    run(2 * FRAME);
    chk("two_rise_hits", 64'(obs_hits - h0), 64'd1);

    // reset at row 5 with an update pending
    framebuffer = 64'hFFFF_FFFF_FFFF_FFFF;
    run_to(5 * RT);
    pulse_update();
    run_to(5 * RT + 4);
    rst = 1'b0;
    step();
    chk("midreset_row_sel", 64'(row_sel), 64'hFF);
    chk("midreset_col_data", 64'(col_data), 64'h00);
    rst = 1'b1;
    player_en = 1'b0;
    run(2 * FRAME);
    run_to(4 * RT + 6);
    chk("post_reset_blank", 64'(col_data), 64'h00);

    // randomized traffic
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 39) == 0) frame_update = ~frame_update;
      if ($urandom_range(0, 63) == 0) framebuffer = {$urandom, $urandom};
      if ($urandom_range(0, 99) == 0) begin
        player_col = 3'($urandom_range(0, 7));
        player_en  = 1'($urandom_range(0, 1));
      end
      rst = ($urandom_range(0, 1999) == 0) ? 1'b0 : 1'b1;
      step();
    end
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
- Consumer side of the falling-stick map generator's 64-bit framebuffer; drives the 8x8 LED matrix.
- Detects each framebuffer update strobe and latches the new map into a shadow buffer, only at frame boundaries, so the display never tears.
- Scans the shadow buffer row by row and overlays the player pixel on the bottom row.
- Flags a collision when a latched stick covers the player column.

Parameters:
- ROW_TICKS, 16, system_clk cycles per row slot; must be greater than BLANK_TICKS.
- BLANK_TICKS, 2, anti-ghost blanking cycles at the start of each row slot.

Ports:
- system_clk  input  1  system clock
- rst  input  1  synchronous reset, active-low (0 = reset)
- framebuffer  input  64  map; row r = framebuffer[8r+7:8r]; row 0 = top (newest), row 7 = bottom; bit=1 lit
- frame_update  input  1  generator update strobe (slow square wave, same clock domain); rising edge = new map
- player_col  input  3  player column on bottom row
- player_en  input  1  enable player overlay and collision check
- row_sel  output  8  active-low one-hot row drive
- col_data  output  8  active-high column data
- frame_start  output  1  one-cycle pulse in first cycle of each frame
- hit  output  1  one-cycle collision pulse

Behaviour:
- Reset (rst=0 at an edge):
  - row=0, tick_cnt=0, state=BLANK, shadow=0, pending=0, upd_d=0.
  - row_sel=8'hFF, col_data=8'h00, frame_start=0, hit=0.
- Counters:
  - tick_cnt runs 0..ROW_TICKS-1 and wraps.
  - row increments on tick_cnt wrap; 7 wraps to 0.
  - Frame = 8*ROW_TICKS cycles (128 at defaults).
- Outputs are registered, loaded from next-state, so they align with the current row/tick_cnt with no lag.
- State machine:
  - BLANK while tick_cnt < BLANK_TICKS: row_sel=8'hFF, col_data=8'h00.
  - DRIVE while tick_cnt >= BLANK_TICKS: row_sel=~(8'b1<<row), col_data=shadow row[row].
  - DRIVE returns to BLANK at tick_cnt wrap.
- Overlay: in DRIVE with row==7 and player_en=1, col_data = shadow row7 | (1<<player_col).
- Update detect:
  - upd_d <= frame_update.
  - rise = frame_update & ~upd_d.
  - A rise sets pending.
  - Multiple rises within one frame collapse into one pending.
- Shadow copy:
  - Copy occurs on the edge where row==7 and tick_cnt==ROW_TICKS-1, if pending, or if rise occurs that same cycle.
  - shadow <= framebuffer sampled at that edge, i.e. the latest value wins.
  - The copy clears pending. A rise arriving in the same cycle as the copy is consumed by that copy.
  - No copy occurs at any other time. The displayed frame is always a single consistent snapshot.
- frame_start = 1 during the cycle with row==0 and tick_cnt==0, once per frame, whether or not a copy occurred.
- hit:
  - In the first cycle of a frame whose shadow was just copied, hit=1 iff player_en=1 and shadow row7[player_col]==1.
  - hit is evaluated once per copy. It does not re-fire on frames without a copy, and player_col changes mid-frame do not cause it to fire.
- Reset mid-operation: everything returns to reset values on the next edge; pending updates are discarded. Scanning resumes at row 0 with a blank display until the first copy.
- Width rules: tick_cnt is wide enough for ROW_TICKS-1; row is 3 bits; no saturating arithmetic.

Test Plan:
- Reset then run 128 cycles with framebuffer=0, no updates:
  - frame_start pulses at cycle 0 and at cycle 128.
  - col_data=0 throughout.
  - row_sel cycles FF(2 cycles), FE(14 cycles), FF, FD, ... FF, 7F.
- framebuffer=64'h0000_0000_0000_00FE with a frame_update rise at cycle 40:
  - Frame 0 stays blank.
  - In frame 1, during row 0 DRIVE cycles, row_sel=FE and col_data=FE; all other rows show 00.
- Tearing check:
  - Set framebuffer=A, issue a rise, then change to B mid-frame before the copy edge.
  - The next frame shows B in every row.
  - Changing framebuffer to C after the copy does not alter the displayed frame until another rise arrives.
- Collision:
  - Latch framebuffer[63:56]=8'hFB with player_en=1.
  - player_col=3 gives hit=1 for exactly 1 cycle at the start of the frame.
  - player_col=2 gives no hit.
  - player_en=0 gives no hit.
  - In both no-hit cases, row 7 col_data is FB, or FF when player_en=1 and player_col=2.
- Two rises within one frame result in a single copy and a single hit evaluation.
- Assert rst=0 at row 5 with pending=1:
  - Next cycle row_sel=FF, col_data=00.
  - After release, the display stays blank until a new rise.
